// File: rtl/i2s_bar_pkg.sv
// Shared types and constants for the I2S bar-graph level scheduler.
// The state encoding, channel ids and level-width helper live here.
package i2s_bar_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_MAG    = 2'd1;
    localparam state_t ST_UPDATE = 2'd2;
    localparam state_t ST_EMIT   = 2'd3;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    // Bits needed to hold a bar level in 0..bars.
    function automatic int level_width(input int bars);
        return $clog2(bars + 1);
    endfunction

endpackage

// File: rtl/level_quantizer.sv
// Combinational sample -> saturated magnitude, and magnitude -> bar level.
// The two halves are split so the scheduler can register the magnitude in between.
module level_quantizer import i2s_bar_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int BARS  = 8,
    parameter int LW    = level_width(BARS)
) (
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] mag,
    input  logic [WIDTH-1:0] mag_q,
    output logic [LW-1:0]    level
);

    localparam int PW = WIDTH + LW;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    logic [PW-1:0] product_s;
    logic [PW-1:0] scaled_s;

    // Absolute value; the most negative code has no positive twin, so clamp it.
    always_comb begin
        mag = sample;
        if (sample == MIN_NEG) begin
            mag = MAX_POS;
        end else if (sample[WIDTH-1]) begin
            mag = -sample;
        end else begin
            mag = sample;
        end
    end

    // Full-width product before the shift so no bits are lost.
    always_comb begin
        product_s = PW'(mag_q) * PW'(BARS);
        scaled_s  = product_s >> (WIDTH - 1);
        if (scaled_s > PW'(BARS)) begin
            level = LW'(BARS);
        end else begin
            level = scaled_s[LW-1:0];
        end
    end

endmodule

// File: rtl/i2s_level_scheduler.sv
// Captures L/R samples from the deserialiser and time-shares one quantise/peak-hold
// path between both channels, emitting bar levels over a valid/ready handshake.
module i2s_level_scheduler import i2s_bar_pkg::*; #(
    parameter int WIDTH       = 16,
    parameter int BARS        = 8,
    parameter int HOLD_FRAMES = 64,
    parameter int LW          = level_width(BARS)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic [WIDTH-1:0] DATA_L,
    input  logic [WIDTH-1:0] DATA_R,
    input  logic             STROBE,
    input  logic             STROBE_LR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_CH,
    output logic [LW-1:0]    OUT_LEVEL,
    output logic [LW-1:0]    OUT_PEAK,
    output logic [1:0]       OVERRUN,
    input  logic             CLR_OVR
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    state_t           state_r;
    logic             strobe_d_r;
    logic [1:0]       pend_r;
    logic             rr_r;
    logic [WIDTH-1:0] sample_r [2];
    logic [WIDTH-1:0] work_r;
    logic             work_ch_r;
    logic [WIDTH-1:0] mag_r;
    logic [LW-1:0]    peak_r [2];
    logic [HW-1:0]    hold_r [2];

    logic             capture_s;
    logic [1:0]       cap_mask_s;
    logic             grant_valid_s;
    logic             grant_ch_s;
    logic [1:0]       clr_mask_s;
    logic [1:0]       ovr_set_s;
    logic [WIDTH-1:0] mag_s;
    logic [LW-1:0]    level_s;
    logic [LW-1:0]    peak_next_s;
    logic [HW-1:0]    hold_next_s;

    level_quantizer #(.WIDTH(WIDTH), .BARS(BARS), .LW(LW)) u_quant (
        .sample (work_r),
        .mag    (mag_s),
        .mag_q  (mag_r),
        .level  (level_s)
    );

    // Capture edge detect and round-robin arbitration between pending channels.
    always_comb begin
        capture_s     = STROBE && !strobe_d_r && ENABLE;
        cap_mask_s    = 2'b00;
        clr_mask_s    = 2'b00;
        grant_valid_s = (state_r == ST_IDLE) && (pend_r != 2'b00);
        if (capture_s) begin
            cap_mask_s = STROBE_LR ? 2'b10 : 2'b01;
        end else begin
            cap_mask_s = 2'b00;
        end
        if (pend_r == 2'b11) begin
            grant_ch_s = ~rr_r;
        end else if (pend_r[1]) begin
            grant_ch_s = CH_R;
        end else begin
            grant_ch_s = CH_L;
        end
        if (grant_valid_s) begin
            clr_mask_s = grant_ch_s ? 2'b10 : 2'b01;
        end else begin
            clr_mask_s = 2'b00;
        end
        // A sample being granted this cycle is consumed, so overwriting it is not lost data.
        ovr_set_s = cap_mask_s & pend_r & ~clr_mask_s;
    end

    // Peak-hold update for the channel currently in the shared path.
    always_comb begin
        peak_next_s = peak_r[work_ch_r];
        hold_next_s = hold_r[work_ch_r];
        if (level_s >= peak_r[work_ch_r]) begin
            peak_next_s = level_s;
            hold_next_s = HW'(0);
        end else if (hold_r[work_ch_r] == HW'(HOLD_FRAMES - 1)) begin
            peak_next_s = (peak_r[work_ch_r] == LW'(0)) ? LW'(0) : peak_r[work_ch_r] - LW'(1);
            hold_next_s = HW'(0);
        end else begin
            hold_next_s = hold_r[work_ch_r] + HW'(1);
        end
    end

    // Sample capture, pending flags and sticky overrun; capture set wins over every clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            strobe_d_r  <= 1'b0;
            pend_r      <= 2'b00;
            OVERRUN     <= 2'b00;
            sample_r[0] <= {WIDTH{1'b0}};
            sample_r[1] <= {WIDTH{1'b0}};
        end else begin
            strobe_d_r <= STROBE;
            pend_r     <= (pend_r & ~clr_mask_s) | cap_mask_s;
            OVERRUN    <= (CLR_OVR ? 2'b00 : OVERRUN) | ovr_set_s;
            if (cap_mask_s[0]) begin
                sample_r[0] <= DATA_L;
            end
            if (cap_mask_s[1]) begin
                sample_r[1] <= DATA_R;
            end
        end
    end

    // Scheduler FSM: grant, magnitude, quantise/peak update, then hold the item until accepted.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= ST_IDLE;
            rr_r      <= CH_L;
            work_r    <= {WIDTH{1'b0}};
            work_ch_r <= CH_L;
            mag_r     <= {WIDTH{1'b0}};
            peak_r[0] <= LW'(0);
            peak_r[1] <= LW'(0);
            hold_r[0] <= HW'(0);
            hold_r[1] <= HW'(0);
            OUT_VALID <= 1'b0;
            OUT_CH    <= 1'b0;
            OUT_LEVEL <= LW'(0);
            OUT_PEAK  <= LW'(0);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        work_r    <= sample_r[grant_ch_s];
                        work_ch_r <= grant_ch_s;
                        rr_r      <= grant_ch_s;
                        state_r   <= ST_MAG;
                    end
                end
                ST_MAG: begin
                    mag_r   <= mag_s;
                    state_r <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    peak_r[work_ch_r] <= peak_next_s;
                    hold_r[work_ch_r] <= hold_next_s;
                    OUT_CH    <= work_ch_r;
                    OUT_LEVEL <= level_s;
                    OUT_PEAK  <= peak_next_s;
                    OUT_VALID <= 1'b1;
                    state_r   <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    OUT_VALID <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_level_scheduler.sv
// Directed bench for i2s_level_scheduler: latency, quantisation, arbitration,
// overrun, peak decay and asynchronous reset, all against hand-computed values.
module tb_i2s_level_scheduler;

    localparam int WIDTH = 16;
    localparam int BARS  = 8;
    localparam int HOLD  = 4;
    localparam int LW    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] data_l = '0;
    logic [WIDTH-1:0] data_r = '0;
    logic             strobe = 1'b0;
    logic             strobe_lr = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_ch;
    logic [LW-1:0]    out_level;
    logic [LW-1:0]    out_peak;
    logic [1:0]       overrun;
    logic             clr_ovr = 1'b0;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    i2s_level_scheduler #(.WIDTH(WIDTH), .BARS(BARS), .HOLD_FRAMES(HOLD)) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .ENABLE    (enable),
        .DATA_L    (data_l),
        .DATA_R    (data_r),
        .STROBE    (strobe),
        .STROBE_LR (strobe_lr),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_CH    (out_ch),
        .OUT_LEVEL (out_level),
        .OUT_PEAK  (out_peak),
        .OVERRUN   (overrun),
        .CLR_OVR   (clr_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        strobe = 1'b0;
        clr_ovr = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        enable = 1'b1;
        tick();
    endtask

    // One-cycle strobe pulse carrying a sample for channel ch; optional clear alongside.
    task automatic send(input logic ch, input logic [WIDTH-1:0] d, input logic clr);
        strobe_lr = ch;
        if (ch) data_r = d; else data_l = d;
        strobe  = 1'b1;
        clr_ovr = clr;
        tick();
        strobe  = 1'b0;
        clr_ovr = 1'b0;
        tick();
    endtask

    task automatic get_item(input string tag, input logic ch, input logic [LW-1:0] lvl,
                            input logic [LW-1:0] pk);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_ch"}, out_ch, ch);
            chk({tag, "_level"}, out_level, lvl);
            chk({tag, "_peak"}, out_peak, pk);
            tick();
        end
    endtask

    task automatic no_item(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk(tag, seen, 1'b0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_level", out_level, 4'd0);
        chk("rst_peak", out_peak, 4'd0);
        chk("rst_ch", out_ch, 1'b0);
        chk("rst_ovr", overrun, 2'b00);

        // 1: exact latency of a lone L capture
        out_ready = 1'b1;
        strobe_lr = 1'b0;
        data_l = 16'h4000;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        tick();
        chk("lat_n3_valid", out_valid, 1'b0);
        tick();
        chk("lat_n4_valid", out_valid, 1'b1);
        chk("lat_ch", out_ch, 1'b0);
        chk("lat_level", out_level, 4'd4);
        chk("lat_peak", out_peak, 4'd4);
        tick();
        chk("lat_consumed", out_valid, 1'b0);

        // 2: quantisation corners on R, and ENABLE gating
        do_reset();
        out_ready = 1'b1;
        send(1'b1, 16'h8000, 1'b0);
        get_item("q_min", 1'b1, 4'd7, 4'd7);
        send(1'b1, 16'h7FFF, 1'b0);
        get_item("q_max", 1'b1, 4'd7, 4'd7);
        send(1'b1, 16'h0000, 1'b0);
        get_item("q_zero", 1'b1, 4'd0, 4'd7);
        send(1'b1, 16'hC000, 1'b0);
        get_item("q_neg", 1'b1, 4'd4, 4'd7);
        enable = 1'b0;
        send(1'b0, 16'h4000, 1'b0);
        no_item("en_blocked", 8);
        enable = 1'b1;

        // 3: both pending with rr=L -> R first
        do_reset();
        out_ready = 1'b0;
        send(1'b0, 16'h2000, 1'b0);
        tick();
        tick();
        chk("arb_stall_valid", out_valid, 1'b1);
        send(1'b0, 16'h6000, 1'b0);
        send(1'b1, 16'h1000, 1'b0);
        out_ready = 1'b1;
        get_item("arb_first", 1'b0, 4'd2, 4'd2);
        get_item("arb_r", 1'b1, 4'd1, 4'd1);
        get_item("arb_l", 1'b0, 4'd6, 4'd6);
        chk("arb_ovr", overrun, 2'b00);

        // 4: overrun while stalled; set beats clear
        do_reset();
        out_ready = 1'b0;
        send(1'b0, 16'h2000, 1'b0);
        tick();
        tick();
        send(1'b0, 16'h4000, 1'b0);
        chk("ovr_none_yet", overrun, 2'b00);
        send(1'b0, 16'h6000, 1'b0);
        chk("ovr_set", overrun, 2'b01);
        send(1'b0, 16'h7FFF, 1'b1);
        chk("ovr_set_beats_clr", overrun, 2'b01);
        out_ready = 1'b1;
        get_item("ovr_stalled", 1'b0, 4'd2, 4'd2);
        get_item("ovr_last", 1'b0, 4'd7, 4'd7);
        no_item("ovr_only_last", 8);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_cleared", overrun, 2'b00);

        // 5: peak hold and decay on L (hold of 4 updates)
        do_reset();
        out_ready = 1'b1;
        send(1'b0, 16'h7FFF, 1'b0);
        get_item("pk_top", 1'b0, 4'd7, 4'd7);
        send(1'b0, 16'h0000, 1'b0);
        get_item("pk_z1", 1'b0, 4'd0, 4'd7);
        send(1'b0, 16'h0000, 1'b0);
        get_item("pk_z2", 1'b0, 4'd0, 4'd7);
        send(1'b0, 16'h0000, 1'b0);
        get_item("pk_z3", 1'b0, 4'd0, 4'd7);
        send(1'b0, 16'h0000, 1'b0);
        get_item("pk_z4", 1'b0, 4'd0, 4'd6);
        send(1'b0, 16'h0000, 1'b0);
        get_item("pk_z5", 1'b0, 4'd0, 4'd6);
        send(1'b0, 16'h0000, 1'b0);
        get_item("pk_z6", 1'b0, 4'd0, 4'd6);
        send(1'b0, 16'h0000, 1'b0);
        get_item("pk_z7", 1'b0, 4'd0, 4'd6);
        send(1'b0, 16'h0000, 1'b0);
        get_item("pk_z8", 1'b0, 4'd0, 4'd5);
        send(1'b1, 16'h0000, 1'b0);
        get_item("pk_r_indep", 1'b1, 4'd0, 4'd0);

        // 6: asynchronous reset during EMIT
        out_ready = 1'b0;
        send(1'b0, 16'h7FFF, 1'b0);
        tick();
        tick();
        chk("ar_emit_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_async", out_valid, 1'b0);
        chk("ar_peak_async", out_peak, 4'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        strobe_lr = 1'b0;
        data_l = 16'h0000;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        tick();
        chk("ar_idle_n3", out_valid, 1'b0);
        tick();
        chk("ar_idle_n4", out_valid, 1'b1);
        chk("ar_peak_cleared", out_peak, 4'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
